fp_norm_left: RTL and testbench



---
 rtl/fp_pkg.sv | 18 +
 rtl/fp_norm_left_shf.sv | 21 ++
 rtl/fp_norm_left.sv | 121 ++++++++++++
 tb/tb_fp_norm_left.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared constants and stage-1 register layout for the floating-point normalizer.
package fp_pkg;

    localparam int SIZE_MAN   = 28;
    localparam int SIZE_EXP   = 8;
    localparam int SIZE_SHIFT = $clog2(SIZE_MAN);
    // Leading-zero count must also represent SIZE_MAN itself (all-zero mantissa).
    localparam int SIZE_LZ    = $clog2(SIZE_MAN + 1);

    typedef struct packed {
        logic [SIZE_MAN-1:0] man;
        logic [SIZE_EXP-1:0] exp;
        logic [SIZE_LZ-1:0]  lz;
        logic                sign;
        logic                is_zero;
    } norm_s1_t;

endpackage

// File: rtl/fp_norm_left_shf.sv
// SHF_left: logarithmic left barrel shifter, zero fill at the LSB.
module SHF_left #(
    parameter int SIZE_DATA  = 28,
    parameter int SIZE_SHIFT = 5
) (
    input  logic [SIZE_SHIFT-1:0] i_shift_number,
    input  logic [SIZE_DATA-1:0]  i_data,
    output logic [SIZE_DATA-1:0]  o_data
);

    logic [SIZE_DATA-1:0] stage [SIZE_SHIFT+1];

    assign stage[0] = i_data;

    for (genvar k = 0; k < SIZE_SHIFT; k++) begin : g_stage
        assign stage[k+1] = i_shift_number[k] ? (stage[k] << (2 ** k)) : stage[k];
    end

    assign o_data = stage[SIZE_SHIFT];

endmodule

// File: rtl/fp_norm_left.sv
// Two-stage mantissa normalizer (LZC, then shift/exponent adjust) with valid/ready.
// Optional build macro NORM_DENORM_EN selects gradual underflow instead of flush-to-zero.
module fp_norm_left
    import fp_pkg::*;
#(
    parameter int SIZE_MAN   = fp_pkg::SIZE_MAN,
    parameter int SIZE_EXP   = fp_pkg::SIZE_EXP,
    parameter int SIZE_SHIFT = fp_pkg::SIZE_SHIFT
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [SIZE_MAN-1:0] i_man,
    input  logic [SIZE_EXP-1:0] i_exp,
    input  logic                i_sign,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [SIZE_MAN-1:0] o_man,
    output logic [SIZE_EXP-1:0] o_exp,
    output logic                o_sign,
    output logic                o_zero,
    output logic                o_underflow
);

    localparam int EXP_W = SIZE_EXP + 1;

    function automatic logic [SIZE_LZ-1:0] count_lz(input logic [SIZE_MAN-1:0] man);
        count_lz = SIZE_LZ'(SIZE_MAN);
        for (int i = 0; i < SIZE_MAN; i++) begin
            if (man[i]) count_lz = SIZE_LZ'(SIZE_MAN - 1 - i);
        end
    endfunction

    norm_s1_t s1;
    logic     s1_v, s2_v, en1, en2;

    assign en2     = !s2_v || i_ready;
    assign en1     = !s1_v || en2;
    assign o_ready = en1;
    assign o_valid = s2_v;

    // Stage 2 combinational: shift amount selection and exponent adjust.
    logic [SIZE_SHIFT-1:0] sh;
    logic [SIZE_MAN-1:0]   shifted, n_man;
    logic [SIZE_EXP-1:0]   n_exp;
    logic                  n_zero, n_uf, keep_man;
    logic [EXP_W-1:0]      exp_w, lz_w;

    assign exp_w = {1'b0, s1.exp};
    assign lz_w  = EXP_W'(s1.lz);

    SHF_left #(
        .SIZE_DATA  (SIZE_MAN),
        .SIZE_SHIFT (SIZE_SHIFT)
    ) u_shf (
        .i_shift_number (sh),
        .i_data         (s1.man),
        .o_data         (shifted)
    );

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sh       = '0;
        n_exp    = '0;
        n_zero   = 1'b0;
        n_uf     = 1'b0;
        keep_man = 1'b1;
        if (s1.is_zero) begin
            n_zero   = 1'b1;
            keep_man = 1'b0;
        end else if (lz_w < exp_w) begin
            sh    = SIZE_SHIFT'(s1.lz);
            n_exp = s1.exp - SIZE_EXP'(s1.lz);
        end else begin
            n_uf = 1'b1;
`ifdef NORM_DENORM_EN
            // exp <= lz < SIZE_MAN here, so exp-1 always fits the shifter.
            sh = (s1.exp == '0) ? '0 : SIZE_SHIFT'(s1.exp - 1'b1);
`else
            n_zero   = 1'b1;
            keep_man = 1'b0;
`endif
        end
        n_man = keep_man ? shifted : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the stage-1 data register is reset too, keeping post-reset state fully deterministic.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_v        <= 1'b0;
            s1          <= '0;
            s2_v        <= 1'b0;
            o_man       <= '0;
            o_exp       <= '0;
            o_sign      <= 1'b0;
            o_zero      <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (en1) begin
                s1_v <= i_valid;
                if (i_valid) begin
                    s1 <= '{man: i_man, exp: i_exp, lz: count_lz(i_man),
                           sign: i_sign, is_zero: (i_man == '0)};
                end
            end
            if (en2) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    o_man       <= n_man;
                    o_exp       <= n_exp;
                    o_sign      <= s1.sign;
                    o_zero      <= n_zero;
                    o_underflow <= n_uf;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_norm_left.sv
// Scoreboard bench for fp_norm_left: driver pushes expected results, monitor pops on output handshake.
module tb_fp_norm_left;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [27:0] i_man;
    logic [7:0]  i_exp;
    logic        i_sign;
    logic        o_valid;
    logic        i_ready;
    logic [27:0] o_man;
    logic [7:0]  o_exp;
    logic        o_sign;
    logic        o_zero;
    logic        o_underflow;

    fp_norm_left dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_man       (i_man),
        .i_exp       (i_exp),
        .i_sign      (i_sign),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_man       (o_man),
        .o_exp       (o_exp),
        .o_sign      (o_sign),
        .o_zero      (o_zero),
        .o_underflow (o_underflow)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;
    logic [38:0] sb [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [38:0] res(input logic [27:0] m, input logic [7:0] e,
                                        input logic s, input logic z, input logic uf);
        return {m, e, s, z, uf};
    endfunction

    function automatic logic [38:0] outs();
        return {o_man, o_exp, o_sign, o_zero, o_underflow};
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [27:0] m, input logic [7:0] e, input logic s,
                        input logic [38:0] expv);
        logic acc = 1'b0;
        int   n   = 0;
        i_valid = 1'b1;
        i_man   = m;
        i_exp   = e;
        i_sign  = s;
        while (!acc) begin
            @(negedge i_clk);
            acc = o_ready;
            @(posedge i_clk);
            if (acc) sb.push_back(expv);
            n++;
            if (!acc && n > 50) begin
                check("send_timeout", 64'd0, 64'd1);
                break;
            end
        end
        #1 i_valid = 1'b0;
    endtask

    // Monitor: compare every consumed result against the oldest expectation.
    initial begin
        forever begin
            @(negedge i_clk);
            if (!i_rst && o_valid && i_ready) begin
                if (sb.size() == 0) check("unexpected_output", 64'(outs()), 64'd0);
                else check("result", 64'(outs()), 64'(sb.pop_front()));
            end
        end
    end

    logic [38:0] exp_a, exp_uf1, exp_uf2, exp_uf3;

    initial begin
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_man   = '0;
        i_exp   = '0;
        i_sign  = 1'b0;
        i_ready = 1'b1;
`ifdef NORM_DENORM_EN
        exp_uf1 = res(28'h0000200, 8'd0, 1'b0, 1'b0, 1'b1);
        exp_uf2 = res(28'h6000000, 8'd0, 1'b1, 1'b0, 1'b1);
        exp_uf3 = res(28'h4000000, 8'd0, 1'b0, 1'b0, 1'b1);
`else
        exp_uf1 = res(28'h0, 8'd0, 1'b0, 1'b1, 1'b1);
        exp_uf2 = res(28'h0, 8'd0, 1'b1, 1'b1, 1'b1);
        exp_uf3 = res(28'h0, 8'd0, 1'b0, 1'b1, 1'b1);
`endif
        exp_a = res(28'h8000000, 8'd126, 1'b1, 1'b0, 1'b0);

        repeat (3) @(posedge i_clk);
        #1;
        check("reset_o_valid", 64'(o_valid), 64'd0);
        check("reset_outputs", 64'(outs()), 64'd0);
        i_rst = 1'b0;
        @(negedge i_clk);
        check("post_reset_o_ready", 64'(o_ready), 64'd1);
        @(posedge i_clk);
        #1;

        // Directed vectors at full throughput
        send(28'h0800000, 8'd130, 1'b1, exp_a);
        send(28'h8000001, 8'd1,   1'b0, res(28'h8000001, 8'd1, 1'b0, 1'b0, 1'b0));
        send(28'h0000000, 8'd200, 1'b1, res(28'h0, 8'd0, 1'b1, 1'b1, 1'b0));
        send(28'h0000001, 8'd10,  1'b0, exp_uf1);
        send(28'h0000003, 8'd27,  1'b0, res(28'hC000000, 8'd1, 1'b0, 1'b0, 1'b0));
        send(28'h0000003, 8'd26,  1'b1, exp_uf2);
        send(28'h4000000, 8'd0,   1'b0, exp_uf3);
        send(28'h1234567, 8'd255, 1'b0, res(28'h91A2B38, 8'd252, 1'b0, 1'b0, 1'b0));
        repeat (4) @(posedge i_clk);
        #1;
        check("drain_after_vectors", 64'(sb.size()), 64'd0);

        // Backpressure: A and B fill the pipe, C waits, outputs hold A
        i_ready = 1'b0;
        send(28'h0800000, 8'd130, 1'b1, exp_a);
        send(28'h0000100, 8'd100, 1'b0, res(28'h8000000, 8'd81, 1'b0, 1'b0, 1'b0));
        @(negedge i_clk);
        check("full_o_ready_low", 64'(o_ready), 64'd0);
        @(posedge i_clk);
        #1;
        fork
            send(28'h8000000, 8'd5, 1'b1, res(28'h8000000, 8'd5, 1'b1, 1'b0, 1'b0));
            begin
                for (int c = 0; c < 4; c++) begin
                    @(negedge i_clk);
                    check("stall_o_valid", 64'(o_valid), 64'd1);
                    check("stall_hold_a", 64'(outs()), 64'(exp_a));
                    @(posedge i_clk);
                end
                #1 i_ready = 1'b1;
                for (int c = 0; c < 3; c++) begin
                    @(negedge i_clk);
                    check("release_consecutive", 64'(o_valid), 64'd1);
                end
            end
        join
        repeat (3) @(posedge i_clk);
        #1;
        check("drain_after_backpressure", 64'(sb.size()), 64'd0);

        // Reset with two beats in flight
        i_ready = 1'b0;
        send(28'h0800000, 8'd130, 1'b1, exp_a);
        send(28'h0000003, 8'd27,  1'b0, res(28'hC000000, 8'd1, 1'b0, 1'b0, 1'b0));
        #2 i_rst = 1'b1;
        #1;
        check("midrst_o_valid", 64'(o_valid), 64'd0);
        check("midrst_outputs", 64'(outs()), 64'd0);
        check("midrst_o_ready", 64'(o_ready), 64'd1);
        sb.delete();
        repeat (2) @(posedge i_clk);
        #1;
        i_rst   = 1'b0;
        i_ready = 1'b1;
        @(negedge i_clk);
        check("after_rst_o_ready", 64'(o_ready), 64'd1);
        for (int c = 0; c < 5; c++) begin
            check("no_stale_beat", 64'(o_valid), 64'd0);
            @(negedge i_clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
